// File: rtl/truth_table_sweep_pkg.sv
// Shared types for the truth-table sweep checker: FSM state encoding and
// a sizing helper for the settle counter.
package truth_table_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A one-cycle settle window still needs a 1-bit counter to stay legal.
  function automatic int settle_width(input int settle_cycles);
    return (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
  endfunction

endpackage

// File: rtl/truth_table_sweep_if.sv
// Bundle between the sweep controller (slave) and the bench/functions side (master).
interface truth_table_sweep_if #(
  parameter int N_IN  = 2,
  parameter int N_OUT = 1
);
  // start is a level request with no ready: it is honoured on any edge where the
  // controller sits in IDLE or DONE and ignored in RUN. busy/done report progress.
  logic              start;
  logic              stop_on_first;
  logic [N_OUT-1:0]  cmp_mask;
  logic [N_IN-1:0]   vec;
  logic [N_OUT-1:0]  resp_a;
  logic [N_OUT-1:0]  resp_b;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_err_vec;
  logic              first_err_valid;

  modport master (
    output start, stop_on_first, cmp_mask, resp_a, resp_b,
    input  vec, busy, done, pass, err_count, first_err_vec, first_err_valid
  );

  modport slave (
    input  start, stop_on_first, cmp_mask, resp_a, resp_b,
    output vec, busy, done, pass, err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/truth_table_sweep_tt_compare.sv
// Masked per-bit comparison of two responses; X/Z on an enabled bit is a mismatch.
module tt_compare #(
  parameter int N_OUT = 1
) (
  input  logic [N_OUT-1:0] resp_a,
  input  logic [N_OUT-1:0] resp_b,
  input  logic [N_OUT-1:0] cmp_mask,
  output logic             mismatch
);

  always_comb begin
    mismatch = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (cmp_mask[i] && (resp_a[i] !== resp_b[i])) mismatch = 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweep.sv
// Exhaustive sweep of an N_IN-input vector space comparing two implementations;
// counts mismatching vectors and captures the first one.
module truth_table_sweep
  import truth_table_sweep_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int N_OUT         = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  truth_table_sweep_if.slave   bus,
  output state_e               state_o
);

  localparam int SW = settle_width(SETTLE_CYCLES);

  state_e            state_q;
  logic [N_IN-1:0]   vec_q;
  logic [SW-1:0]     settle_q;
  logic [N_IN:0]     err_count_q;
  logic [N_IN:0]     err_count_d;
  logic [N_IN-1:0]   first_err_vec_q;
  logic              first_err_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              stop_on_first_q;
  logic [N_OUT-1:0]  cmp_mask_q;
  logic              mismatch;
  logic              settle_hit;
  logic              last_vec;

  tt_compare #(.N_OUT(N_OUT)) u_cmp (
    .resp_a   (bus.resp_a),
    .resp_b   (bus.resp_b),
    .cmp_mask (cmp_mask_q),
    .mismatch (mismatch)
  );

  always_comb begin
    err_count_d = err_count_q + {{N_IN{1'b0}}, mismatch};
    settle_hit  = (settle_q == SW'(SETTLE_CYCLES - 1));
    last_vec    = &vec_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      vec_q             <= '0;
      settle_q          <= '0;
      err_count_q       <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      stop_on_first_q   <= 1'b0;
      cmp_mask_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q           <= ST_RUN;
            vec_q             <= '0;
            settle_q          <= '0;
            err_count_q       <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
            busy_q            <= 1'b1;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            stop_on_first_q   <= bus.stop_on_first;
            cmp_mask_q        <= bus.cmp_mask;
          end
        end
        ST_RUN: begin
          if (!settle_hit) begin
            settle_q <= settle_q + SW'(1);
          end else begin
            err_count_q <= err_count_d;
            if (mismatch && !first_err_valid_q) begin
              first_err_vec_q   <= vec_q;
              first_err_valid_q <= 1'b1;
            end
            // The sweep ends on the all-ones vector, so vec never wraps.
            if (last_vec || (stop_on_first_q && mismatch)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == '0);
            end else begin
              vec_q    <= vec_q + N_IN'(1);
              settle_q <= '0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec             = vec_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_vec   = first_err_vec_q;
  assign bus.first_err_valid = first_err_valid_q;
  assign state_o             = state_q;

endmodule

// File: tb/tb_truth_table_sweep.sv
// Bench for truth_table_sweep: two instances (2-input/1-cycle settle and
// 3-input/3-cycle settle) driven by small reference functions.
module tb_truth_table_sweep;
  import truth_table_sweep_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   rst0, rst1;
  state_e st0, st1;
  int     mode0;

  truth_table_sweep_if #(.N_IN(2), .N_OUT(1)) if0 ();
  truth_table_sweep_if #(.N_IN(3), .N_OUT(1)) if1 ();

  truth_table_sweep #(.N_IN(2), .N_OUT(1), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0.slave), .state_o(st0)
  );
  truth_table_sweep #(.N_IN(3), .N_OUT(1), .SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1.slave), .state_o(st1)
  );

  // Functions under comparison: 0 = XOR/XOR, 1 = XOR/NAND, 2 = X injected at vec 01.
  always_comb begin
    if0.resp_a = ^if0.vec;
    if0.resp_b = ^if0.vec;
    case (mode0)
      1: if0.resp_b = ~&if0.vec;
      2: if (if0.vec == 2'b01) if0.resp_a = 1'bx;
      default: ;
    endcase
  end
  assign if1.resp_a = ^if1.vec;
  assign if1.resp_b = ^if1.vec;

  int n_tests = 0;
  int n_fail  = 0;
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int sel, input bit st, input bit sof, input bit mask);
    if (sel == 0) begin
      if0.start = st; if0.stop_on_first = sof; if0.cmp_mask = mask;
    end else begin
      if1.start = st; if1.stop_on_first = sof; if1.cmp_mask = mask;
    end
  endtask

  task automatic snap(input int sel, output int v, output int e, output int fv,
                      output int fvv, output int p, output int d, output int b, output int s);
    if (sel == 0) begin
      v = int'(if0.vec); e = int'(if0.err_count); fv = int'(if0.first_err_vec);
      fvv = int'(if0.first_err_valid); p = int'(if0.pass); d = int'(if0.done);
      b = int'(if0.busy); s = int'(st0);
    end else begin
      v = int'(if1.vec); e = int'(if1.err_count); fv = int'(if1.first_err_vec);
      fvv = int'(if1.first_err_valid); p = int'(if1.pass); d = int'(if1.done);
      b = int'(if1.busy); s = int'(st1);
    end
  endtask

  task automatic check_reset(input int sel);
    int v, e, fv, fvv, p, d, b, s;
    snap(sel, v, e, fv, fvv, p, d, b, s);
    check($sformatf("rst%0d_vec", sel), v, 0);
    check($sformatf("rst%0d_err", sel), e, 0);
    check($sformatf("rst%0d_fev", sel), fv, 0);
    check($sformatf("rst%0d_fevv", sel), fvv, 0);
    check($sformatf("rst%0d_pass", sel), p, 0);
    check($sformatf("rst%0d_done", sel), d, 0);
    check($sformatf("rst%0d_busy", sel), b, 0);
    check($sformatf("rst%0d_state", sel), s, int'(ST_IDLE));
  endtask

  // Push the expected outcome, run one sweep, pop and compare when done rises.
  task automatic run_sweep(input string name, input int sel, input int s_cyc, input int vmax,
                           input bit sof, input bit mask, input int e_err, input int e_fev,
                           input int e_fevv, input int e_pass, input int e_vec, input int e_edge,
                           input bit trace, input int ign_edge);
    int v, e, fv, fvv, p, d, b, s;
    int done_edge;
    logic [47:0] exp;
    exp_q.push_back({8'(e_pass), 8'(e_fevv), 8'(e_fev), 8'(e_err), 8'(e_vec), 8'(e_edge)});
    @(negedge clk);
    drive(sel, 1'b1, sof, mask);
    @(posedge clk);
    #1;
    // Flipping the mask after the start edge must not affect the result.
    drive(sel, 1'b0, sof, ~mask);
    snap(sel, v, e, fv, fvv, p, d, b, s);
    check({name, "_busy_at_start"}, b, 1);
    check({name, "_state_run"}, s, int'(ST_RUN));
    done_edge = -1;
    for (int k = 1; k <= 400; k++) begin
      drive(sel, (k == ign_edge), sof, ~mask);
      @(posedge clk);
      #1;
      snap(sel, v, e, fv, fvv, p, d, b, s);
      if (trace) check($sformatf("%s_vec_e%0d", name, k), v, ((k / s_cyc) > vmax) ? vmax : (k / s_cyc));
      if (d == 1) begin
        done_edge = k;
        break;
      end
    end
    drive(sel, 1'b0, sof, mask);
    if (done_edge < 0) check({name, "_timeout"}, done_edge, e_edge);
    exp = exp_q.pop_front();
    check({name, "_done_edge"}, done_edge, int'(exp[7:0]));
    check({name, "_vec"}, v, int'(exp[15:8]));
    check({name, "_err"}, e, int'(exp[23:16]));
    check({name, "_fev"}, fv, int'(exp[31:24]));
    check({name, "_fevv"}, fvv, int'(exp[39:32]));
    check({name, "_pass"}, p, int'(exp[47:40]));
    check({name, "_busy_done"}, b, 0);
    check({name, "_state_done"}, s, int'(ST_DONE));
  endtask

  initial begin
    int v, e, fv, fvv, p, d, b, s;
    rst0 = 1'b1; rst1 = 1'b1; mode0 = 0;
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    mode0 = 0;
    run_sweep("xor_eq", 0, 1, 3, 1'b0, 1'b1, 0, 0, 0, 1, 3, 4, 1'b1, 0);
    repeat (2) @(posedge clk);
    #1;
    snap(0, v, e, fv, fvv, p, d, b, s);
    check("done_held", d, 1);
    check("vec_held", v, 3);

    mode0 = 1;
    run_sweep("xor_nand", 0, 1, 3, 1'b0, 1'b1, 1, 0, 1, 0, 3, 4, 1'b1, 0);
    run_sweep("stop_first", 0, 1, 3, 1'b1, 1'b1, 1, 0, 1, 0, 0, 1, 1'b0, 0);
    mode0 = 0;
    run_sweep("rerun", 0, 1, 3, 1'b0, 1'b1, 0, 0, 0, 1, 3, 4, 1'b0, 0);

    mode0 = 2;
    run_sweep("x_inject", 0, 1, 3, 1'b0, 1'b1, 1, 1, 1, 0, 3, 4, 1'b0, 0);
    run_sweep("mask_off", 0, 1, 3, 1'b0, 1'b0, 0, 0, 0, 1, 3, 4, 1'b0, 0);

    run_sweep("settle3", 1, 3, 7, 1'b0, 1'b1, 0, 0, 0, 1, 7, 24, 1'b1, 5);

    // Reset in the middle of a sweep, then a clean restart.
    mode0 = 1;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    check_reset(0);
    rst0 = 1'b0;
    mode0 = 0;
    run_sweep("after_rst", 0, 1, 3, 1'b0, 1'b1, 0, 0, 0, 1, 3, 4, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
